// File: rtl/sprite_commit_ctrl.sv
// Frame-synchronous sprite register commit: shadow bank written by the bus, dirty entries
// copied to the renderer once per vblank. Optional commit-done irq via SPRITE_COMMIT_IRQ_EN.
module sprite_commit_ctrl #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ANIM_DIV_RST = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic [8:0]                  address,
  input  logic [31:0]                 writedata,
  input  logic                        vga_blank_n,
  input  logic [9:0]                  vcount,
  output logic                        reg_we,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr,
  output logic [DATA_W-1:0]           reg_data,
  output logic [1:0]                  anim_phase,
  output logic                        busy,
  output logic [15:0]                 frame_cnt,
  output logic                        irq
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_shadow [NUM_REGS];
  logic [NUM_REGS-1:0] r_dirty;
  logic [7:0]          r_anim_div;
  logic [7:0]          r_div_cnt;
  logic [1:0]          r_anim_phase;
  logic [15:0]         r_frame_cnt;
  logic                r_busy;
  logic                r_reg_we;
  logic [IDX_W-1:0]    r_reg_addr;
  logic [DATA_W-1:0]   r_reg_data;
  logic                r_blank_d1;

  logic             w_vb;
  logic             w_wr;
  logic             w_wr_reg;
  logic             w_wr_div;
  logic [IDX_W-1:0] w_wr_idx;
  logic [7:0]       w_div_eff;
  logic             w_div_wrap;
  logic             w_scan_last;
  logic             w_unused_wdata;

  assign w_vb        = r_blank_d1 & ~vga_blank_n & (vcount >= 10'd480);
  assign w_wr        = chipselect & write;
  assign w_wr_reg    = w_wr && (32'(address) < NUM_REGS);
  assign w_wr_div    = w_wr && (address == 9'h1F0);
  assign w_wr_idx    = address[IDX_W-1:0];
  assign w_div_eff   = (r_anim_div == 8'd0) ? 8'd1 : r_anim_div;
  assign w_div_wrap  = (r_div_cnt >= (w_div_eff - 8'd1));
  assign w_scan_last = (r_state == StScan) && (r_idx == LastIdx);
  assign w_unused_wdata = ^writedata[31:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_d1 <= 1'b0;
    end else begin
      r_blank_d1 <= vga_blank_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) r_shadow[i] <= '0;
      r_dirty      <= '0;
      r_anim_div   <= 8'(ANIM_DIV_RST);
      r_div_cnt    <= 8'd0;
      r_anim_phase <= 2'd0;
      r_frame_cnt  <= 16'd0;
      r_busy       <= 1'b0;
      r_reg_we     <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_data   <= '0;
    end else begin
      r_reg_we <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_vb) begin
            r_state     <= StScan;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_div_wrap) begin
              r_div_cnt    <= 8'd0;
              r_anim_phase <= r_anim_phase + 2'd1;
            end else begin
              r_div_cnt <= r_div_cnt + 8'd1;
            end
          end
        end
        StScan: begin
          if (r_dirty[r_idx]) begin
            r_reg_we       <= 1'b1;
            r_reg_addr     <= r_idx;
            r_reg_data     <= r_shadow[r_idx];
            r_dirty[r_idx] <= 1'b0;
          end
          r_idx <= r_idx + IDX_W'(1);
          if (w_scan_last) r_state <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
      // A bus write after the commit clear keeps the entry dirty on a same-index collision.
      if (w_wr_reg) begin
        r_shadow[w_wr_idx] <= writedata[DATA_W-1:0];
        r_dirty[w_wr_idx]  <= 1'b1;
      end
      if (w_wr_div) r_anim_div <= writedata[7:0];
    end
  end

`ifdef SPRITE_COMMIT_IRQ_EN
  logic r_irq;

  // Set on entry to DONE; set takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if (w_scan_last) begin
      r_irq <= 1'b1;
    end else if (w_wr && (address == 9'h1FF)) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign reg_we     = r_reg_we;
  assign reg_addr   = r_reg_addr;
  assign reg_data   = r_reg_data;
  assign anim_phase = r_anim_phase;
  assign busy       = r_busy;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Directed bench for sprite_commit_ctrl; irq expectations follow SPRITE_COMMIT_IRQ_EN.
module tb_sprite_commit_ctrl;

`ifdef SPRITE_COMMIT_IRQ_EN
  localparam int IrqFirstExp = 16;
  localparam logic IrqHoldExp = 1'b1;
`else
  localparam int IrqFirstExp = -1;
  localparam logic IrqHoldExp = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic        write;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic        vga_blank_n;
  logic [9:0]  vcount;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [15:0] reg_data;
  logic [1:0]  anim_phase;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        irq;

  int n_vec;
  int n_err;

  int          n_commit;
  logic [3:0]  c_addr [32];
  logic [15:0] c_data [32];
  int          c_cyc  [32];
  int          busy_n;
  int          irq_first;

  sprite_commit_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .vga_blank_n(vga_blank_n),
    .vcount     (vcount),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .anim_phase (anim_phase),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    chipselect  = 1'b0;
    write       = 1'b0;
    address     = '0;
    writedata   = '0;
    vga_blank_n = 1'b1;
    vcount      = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  // One vblank; up to two bus writes at scan cycles w*_c, optional extra vb edge at vb2_c.
  task automatic vblank(input int w1_c, input logic [8:0] w1_a, input logic [31:0] w1_d,
                        input int w2_c, input logic [8:0] w2_a, input logic [31:0] w2_d,
                        input int vb2_c);
    n_commit  = 0;
    busy_n    = 0;
    irq_first = -1;
    vcount      = 10'd480;
    vga_blank_n = 1'b0;
    tick();
    for (int c = 0; c < 22; c++) begin
      if (reg_we && n_commit < 32) begin
        c_addr[n_commit] = reg_addr;
        c_data[n_commit] = reg_data;
        c_cyc[n_commit]  = c;
        n_commit++;
      end
      if (busy) busy_n++;
      if (irq && irq_first < 0) irq_first = c;
      chipselect = 1'b0;
      write      = 1'b0;
      if (c == w1_c) begin
        chipselect = 1'b1; write = 1'b1; address = w1_a; writedata = w1_d;
      end else if (c == w2_c) begin
        chipselect = 1'b1; write = 1'b1; address = w2_a; writedata = w2_d;
      end
      if (c == vb2_c - 1) vga_blank_n = 1'b1;
      if (c == vb2_c) vga_blank_n = 1'b0;
      tick();
    end
    chipselect  = 1'b0;
    write       = 1'b0;
    vga_blank_n = 1'b1;
    vcount      = 10'd0;
    tick();
  endtask

  task automatic vblank_plain();
    vblank(-1, 9'd0, 32'd0, -1, 9'd0, 32'd0, -10);
  endtask

  logic [1:0] phase_exp [8];

  initial begin
    n_vec = 0;
    n_err = 0;
    phase_exp[0] = 2'd0; phase_exp[1] = 2'd1; phase_exp[2] = 2'd1; phase_exp[3] = 2'd2;
    phase_exp[4] = 2'd2; phase_exp[5] = 2'd3; phase_exp[6] = 2'd3; phase_exp[7] = 2'd0;

    // Reset state, then an empty vblank
    do_reset();
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_data", 32'(reg_data), 32'd0);
    check("rst_anim_phase", 32'(anim_phase), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    vblank_plain();
    check("empty_commits", 32'(n_commit), 32'd0);
    check("empty_frame_cnt", 32'(frame_cnt), 32'd1);
    check("empty_anim_phase", 32'(anim_phase), 32'd0);
    check("empty_busy_cycles", 32'(busy_n), 32'd17);
    check("irq_first_cycle", 32'(irq_first), 32'(IrqFirstExp));
    check("irq_hold", 32'(irq), 32'(IrqHoldExp));
    bus_write(9'h1FF, 32'd0);
    check("irq_clear", 32'(irq), 32'd0);

    // Two dirty entries committed 3 cycles apart, nothing before vblank
    bus_write(9'd0, 32'd100);
    bus_write(9'd3, 32'hABCD_00C8);
    for (int i = 0; i < 3; i++) begin
      check("idle_no_we", 32'(reg_we), 32'd0);
      tick();
    end
    vblank_plain();
    check("two_commits", 32'(n_commit), 32'd2);
    check("c0_addr", 32'(c_addr[0]), 32'd0);
    check("c0_data", 32'(c_data[0]), 32'd100);
    check("c0_cycle", 32'(c_cyc[0]), 32'd1);
    check("c1_addr", 32'(c_addr[1]), 32'd3);
    check("c1_data", 32'(c_data[1]), 32'd200);
    check("c1_gap", 32'(c_cyc[1] - c_cyc[0]), 32'd3);
    check("frame_cnt_2", 32'(frame_cnt), 32'd2);
    // Out-of-range writes ignored; a vb edge mid-scan is ignored too
    bus_write(9'd16, 32'd1);
    bus_write(9'h100, 32'd2);
    vblank(-1, 9'd0, 32'd0, -1, 9'd0, 32'd0, 8);
    check("second_commits", 32'(n_commit), 32'd0);
    check("busy_vb_ignored", 32'(frame_cnt), 32'd3);
    check("busy_cycles_2", 32'(busy_n), 32'd17);

    // Collision at idx 2 and a write ahead of the scan pointer
    bus_write(9'd2, 32'd10);
    vblank(2, 9'd2, 32'd55, 5, 9'd12, 32'd77, -10);
    check("coll_commits", 32'(n_commit), 32'd2);
    check("coll_addr", 32'(c_addr[0]), 32'd2);
    check("coll_old_data", 32'(c_data[0]), 32'd10);
    check("ahead_addr", 32'(c_addr[1]), 32'd12);
    check("ahead_data", 32'(c_data[1]), 32'd77);
    check("ahead_cycle", 32'(c_cyc[1]), 32'd13);
    vblank_plain();
    check("coll_next_commits", 32'(n_commit), 32'd1);
    check("coll_next_addr", 32'(c_addr[0]), 32'd2);
    check("coll_next_data", 32'(c_data[0]), 32'd55);

    // Async reset while the scan sits at idx 7
    bus_write(9'd5, 32'h55);
    bus_write(9'd8, 32'h88);
    bus_write(9'd9, 32'h99);
    vcount      = 10'd480;
    vga_blank_n = 1'b0;
    tick();
    repeat (7) tick();
    check("pre_rst_addr", 32'(reg_addr), 32'd5);
    check("pre_rst_data", 32'(reg_data), 32'h55);
    reset_n = 1'b0;
    #1;
    check("async_reg_we", 32'(reg_we), 32'd0);
    check("async_reg_addr", 32'(reg_addr), 32'd0);
    check("async_reg_data", 32'(reg_data), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_frame_cnt", 32'(frame_cnt), 32'd0);
    check("async_irq", 32'(irq), 32'd0);
    vga_blank_n = 1'b1;
    vcount      = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    vblank_plain();
    check("post_rst_commits", 32'(n_commit), 32'd0);
    check("post_rst_frame", 32'(frame_cnt), 32'd1);

    // Animation divider of 2 from a fresh reset, then divider 0 acting as 1
    do_reset();
    bus_write(9'h1F0, 32'd2);
    for (int i = 0; i < 8; i++) begin
      vblank_plain();
      check($sformatf("anim_phase_%0d", i), 32'(anim_phase), 32'(phase_exp[i]));
    end
    check("anim_frame_cnt", 32'(frame_cnt), 32'd8);
    bus_write(9'h1F0, 32'd0);
    vblank_plain();
    check("div0_phase_a", 32'(anim_phase), 32'd1);
    vblank_plain();
    check("div0_phase_b", 32'(anim_phase), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
